// File: rtl/alu_sequencer_pkg.sv
// Shared opcode, state and control-bundle definitions for the ALU sequencer.
package alu_sequencer_pkg;

  localparam int unsigned OPCODE_W = 3;

  // Baby opcodes
  typedef enum logic [OPCODE_W-1:0] {
    OP_JMP  = 3'd0,
    OP_JRP  = 3'd1,
    OP_LDN  = 3'd2,
    OP_STO  = 3'd3,
    OP_SUB4 = 3'd4,
    OP_SUB5 = 3'd5,
    OP_CMP  = 3'd6,
    OP_STP  = 3'd7
  } opcode_e;

  // Sequencer states; encoding 3'd7 is unused and decodes to IDLE
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LATCH = 3'd2,
    S_HOLD  = 3'd3,
    S_DRIVE = 3'd4,
    S_WB    = 3'd5,
    S_FIN   = 3'd6
  } state_e;

  // Registered control outputs driven towards the ALU and the accumulator
  typedef struct packed {
    logic busy;
    logic done;
    logic skip;
    logic stop;
    logic sub;
    logic a_zero;
    logic le;
    logic oe_n;
    logic acc_le;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{
    busy: 1'b0, done: 1'b0, skip: 1'b0, stop: 1'b0, sub: 1'b0,
    a_zero: 1'b0, le: 1'b0, oe_n: 1'b1, acc_le: 1'b0
  };

  // Opcodes that go through the ALU (LDN and both SUB encodings)
  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDN) || (op == OP_SUB4) || (op == OP_SUB5);
  endfunction

endpackage

// File: rtl/alu_sequencer_phase_counter.sv
// Loadable down-counter that stops at 1 and flags the terminal count.
module phase_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;

  // Reload on state entry, otherwise count down to 1; terminal count is registered
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      tc_q    <= 1'b1;
    end else if (load_i) begin
      count_q <= load_val_i;
      tc_q    <= (load_val_i <= WIDTH'(1));
    end else if (count_q > WIDTH'(1)) begin
      count_q <= count_q - WIDTH'(1);
      tc_q    <= (count_q <= WIDTH'(2));
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/alu_sequencer.sv
// Control-timing stage ahead of the ALU: sequences SUB/LE/OE_n/ACC_LE for LDN
// and SUB, and resolves CMP and STP locally.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LATCH_CYCLES  = 2
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                START,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                ACC_SIGN,
  output logic                BUSY,
  output logic                DONE,
  output logic                SKIP,
  output logic                STOP,
  output logic                SUB,
  output logic                A_ZERO,
  output logic                LE,
  output logic                OE_n,
  output logic                ACC_LE
);

  localparam int unsigned MAX_CYC = (SETTLE_CYCLES > LATCH_CYCLES) ? SETTLE_CYCLES : LATCH_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_e           state_q, state_d;
  logic             ldn_q, ldn_d;
  ctl_t             ctl_q, ctl_d;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;

  assign accept = (state_q == S_IDLE) && START && !ctl_q.stop;

  phase_counter #(
    .WIDTH (CNT_W)
  ) u_phase_counter (
    .clk_i      (CLK),
    .rst_ni     (RST_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc)
  );

  // State, operand-select and output registers
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      ldn_q   <= 1'b0;
      ctl_q   <= CTL_RESET;
    end else begin
      state_q <= state_d;
      ldn_q   <= ldn_d;
      ctl_q   <= ctl_d;
    end
  end

  // Next-state and phase-counter reload on each state entry
  always_comb begin
    state_d  = state_q;
    ldn_d    = ldn_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ldn_d    = (OPCODE == OP_LDN);
          cnt_load = 1'b1;
          if (is_alu_op(OPCODE)) begin
            state_d = S_SETUP;
            cnt_val = CNT_W'(SETTLE_CYCLES);
          end else begin
            state_d = S_FIN;
            cnt_val = CNT_W'(1);
          end
        end
      end
      S_SETUP: begin
        if (cnt_tc) begin
          state_d  = S_LATCH;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(LATCH_CYCLES);
        end
      end
      S_LATCH: begin
        if (cnt_tc) begin
          state_d  = S_HOLD;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(1);
        end
      end
      S_HOLD: begin
        state_d  = S_DRIVE;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(SETTLE_CYCLES);
      end
      S_DRIVE: begin
        if (cnt_tc) begin
          state_d  = S_WB;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(1);
        end
      end
      S_WB: begin
        state_d  = S_FIN;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(1);
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ldn_d   = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so every control is registered with it
  always_comb begin
    ctl_d      = CTL_RESET;
    ctl_d.stop = ctl_q.stop | (accept && (OPCODE == OP_STP));
    unique case (state_d)
      S_SETUP, S_HOLD: begin
        ctl_d.busy   = 1'b1;
        ctl_d.sub    = 1'b1;
        ctl_d.a_zero = ldn_d;
      end
      S_LATCH: begin
        ctl_d.busy   = 1'b1;
        ctl_d.sub    = 1'b1;
        ctl_d.a_zero = ldn_d;
        ctl_d.le     = 1'b1;
      end
      S_DRIVE: begin
        ctl_d.busy   = 1'b1;
        ctl_d.sub    = 1'b1;
        ctl_d.a_zero = ldn_d;
        ctl_d.oe_n   = 1'b0;
      end
      S_WB: begin
        ctl_d.busy   = 1'b1;
        ctl_d.sub    = 1'b1;
        ctl_d.a_zero = ldn_d;
        ctl_d.oe_n   = 1'b0;
        ctl_d.acc_le = 1'b1;
      end
      S_FIN: begin
        ctl_d.busy = 1'b1;
        ctl_d.done = 1'b1;
        ctl_d.skip = accept && (OPCODE == OP_CMP) && ACC_SIGN;
      end
      default: ;
    endcase
  end

  assign BUSY   = ctl_q.busy;
  assign DONE   = ctl_q.done;
  assign SKIP   = ctl_q.skip;
  assign STOP   = ctl_q.stop;
  assign SUB    = ctl_q.sub;
  assign A_ZERO = ctl_q.a_zero;
  assign LE     = ctl_q.le;
  assign OE_n   = ctl_q.oe_n;
  assign ACC_LE = ctl_q.acc_le;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU/accumulator model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        CLK;
  logic        RST_n;
  logic        START;
  logic [2:0]  OPCODE;
  logic        ACC_SIGN;
  logic        BUSY, DONE, SKIP, STOP, SUB, A_ZERO, LE, OE_n, ACC_LE;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] le_m, oel_m, accle_m, done_m, busy_m, sub_m, az_m, skip_m;

  // ALU / accumulator model driven by the sequencer controls
  logic [31:0] acc_reg = 32'd0;
  logic [31:0] mem_val = 32'd0;
  logic [31:0] alu_a, alu_result;
  logic [31:0] captured = 32'd0;
  int          cap_cnt = 0;
  int          cap0;

  alu_sequencer #(
    .SETTLE_CYCLES (4),
    .LATCH_CYCLES  (2)
  ) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .START    (START),
    .OPCODE   (OPCODE),
    .ACC_SIGN (ACC_SIGN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .SKIP     (SKIP),
    .STOP     (STOP),
    .SUB      (SUB),
    .A_ZERO   (A_ZERO),
    .LE       (LE),
    .OE_n     (OE_n),
    .ACC_LE   (ACC_LE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    alu_a      = A_ZERO ? 32'd0 : acc_reg;
    alu_result = SUB ? (alu_a - mem_val) : (alu_a + mem_val);
  end

  always @(posedge CLK) begin
    if (ACC_LE) begin
      captured <= alu_result;
      cap_cnt  <= cap_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {BUSY, DONE, SKIP, STOP, SUB, A_ZERO, LE, OE_n, ACC_LE};
  endfunction

  task automatic clear_masks();
    le_m = '0; oel_m = '0; accle_m = '0; done_m = '0;
    busy_m = '0; sub_m = '0; az_m = '0; skip_m = '0;
    cyc = 0;
  endtask

  // Advance one cycle, sample away from the rising edge, record and check invariants
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (cyc < 32) begin
      if (LE)     le_m[cyc]    = 1'b1;
      if (!OE_n)  oel_m[cyc]   = 1'b1;
      if (ACC_LE) accle_m[cyc] = 1'b1;
      if (DONE)   done_m[cyc]  = 1'b1;
      if (BUSY)   busy_m[cyc]  = 1'b1;
      if (SUB)    sub_m[cyc]   = 1'b1;
      if (A_ZERO) az_m[cyc]    = 1'b1;
      if (SKIP)   skip_m[cyc]  = 1'b1;
    end
    chk("inv_le_oe", 32'(LE & ~OE_n), 32'd0);
    chk("inv_accle_oe", 32'(ACC_LE & OE_n), 32'd0);
    chk("inv_done_accle", 32'(DONE & ACC_LE), 32'd0);
    if (dut.state_q == S_IDLE) chk("inv_busy_idle", 32'(BUSY), 32'd0);
  endtask

  // Present a one-cycle START; returns sampled in cycle 1
  task automatic start_op(input logic [2:0] op, input logic sign);
    clear_masks();
    START    = 1'b1;
    OPCODE   = op;
    ACC_SIGN = sign;
    step();
    START    = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    RST_n = 1'b0; START = 1'b0; OPCODE = 3'd0; ACC_SIGN = 1'b0;
    clear_masks();
    steps(3);
    chk("por_outputs", 32'(outs()), 32'h002);
    RST_n = 1'b1;
    steps(2);

    // Reset in the middle of a SUB sequence
    cap0 = cap_cnt;
    start_op(3'd4, 1'b0);
    steps(5);
    RST_n = 1'b0;
    steps(3);
    chk("rst_mid_outputs", 32'(outs()), 32'h002);
    RST_n = 1'b1;
    steps(8);
    chk("rst_mid_no_done", done_m, 32'h0);
    chk("rst_mid_no_accle", accle_m, 32'h0);
    chk("rst_mid_no_capture", 32'(cap_cnt - cap0), 32'd0);
    chk("rst_mid_idle", 32'(outs()), 32'h002);

    // SUB: ACC=10, M=4
    acc_reg = 32'd10; mem_val = 32'd4;
    cap0 = cap_cnt;
    start_op(3'd4, 1'b0);
    steps(15);
    chk("sub_le", le_m, 32'h0000_0060);
    chk("sub_oe_low", oel_m, 32'h0000_1F00);
    chk("sub_acc_le", accle_m, 32'h0000_1000);
    chk("sub_done", done_m, 32'h0000_2000);
    chk("sub_busy", busy_m, 32'h0000_3FFE);
    chk("sub_sub", sub_m, 32'h0000_1FFE);
    chk("sub_azero", az_m, 32'h0);
    chk("sub_result", captured, 32'd6);
    chk("sub_capture_cnt", 32'(cap_cnt - cap0), 32'd1);

    // SUB via opcode 5 gives the same timing
    start_op(3'd5, 1'b0);
    steps(15);
    chk("sub5_done", done_m, 32'h0000_2000);
    chk("sub5_sub", sub_m, 32'h0000_1FFE);

    // LDN: M=5, result = 0 - 5
    acc_reg = 32'd10; mem_val = 32'd5;
    start_op(3'd2, 1'b0);
    steps(15);
    chk("ldn_azero", az_m, 32'h0000_1FFE);
    chk("ldn_sub", sub_m, 32'h0000_1FFE);
    chk("ldn_done", done_m, 32'h0000_2000);
    chk("ldn_result", captured, 32'hFFFF_FFFB);

    // CMP with negative accumulator
    start_op(3'd6, 1'b1);
    chk("cmp1_done_c1", 32'(DONE), 32'd1);
    chk("cmp1_skip_c1", 32'(SKIP), 32'd1);
    steps(3);
    chk("cmp1_done", done_m, 32'h2);
    chk("cmp1_skip", skip_m, 32'h2);
    chk("cmp1_le", le_m, 32'h0);
    chk("cmp1_oe", oel_m, 32'h0);
    chk("cmp1_sub", sub_m, 32'h0);

    // CMP with positive accumulator
    start_op(3'd6, 1'b0);
    chk("cmp0_done_c1", 32'(DONE), 32'd1);
    steps(3);
    chk("cmp0_skip", skip_m, 32'h0);

    // JMP: completes in cycle 1 with no ALU activity
    start_op(3'd0, 1'b1);
    steps(3);
    chk("jmp_done", done_m, 32'h2);
    chk("jmp_skip", skip_m, 32'h0);
    chk("jmp_sub", sub_m, 32'h0);

    // Second START during SETUP is ignored
    start_op(3'd4, 1'b0);
    steps(2);
    START = 1'b1; OPCODE = 3'd4;
    step();
    START = 1'b0;
    steps(12);
    chk("restart_done", done_m, 32'h0000_2000);
    chk("restart_busy", busy_m, 32'h0000_3FFE);

    // STP sets sticky STOP and blocks later STARTs
    start_op(3'd7, 1'b0);
    chk("stp_stop_c1", 32'(STOP), 32'd1);
    chk("stp_done_c1", 32'(DONE), 32'd1);
    steps(3);
    chk("stp_done", done_m, 32'h2);
    start_op(3'd4, 1'b0);
    steps(5);
    chk("stp_blocked_busy", busy_m, 32'h0);
    chk("stp_blocked_done", done_m, 32'h0);
    chk("stp_sticky", 32'(STOP), 32'd1);
    RST_n = 1'b0;
    step();
    RST_n = 1'b1;
    step();
    chk("stp_cleared", 32'(STOP), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
